store_stream_checker: RTL
=========================

Name: store_stream_checker

Overview:
- Synthesisable, parametrised checker for the data-memory write port of the pipelined core (MemWrite, DataAdr, WriteData).
- Compares every store against an ordered queue of expected (address, data) pairs loaded by the bench or a boot ROM.
- Counts passes and fails, ignores a configurable scratch address window, and detects a completion signature.
- Reports final verdict and first-failure details, so self-checking runs work in simulation and on FPGA.

Parameters:
- XLEN, 32, data and address width.
- DEPTH, 64, expected-entry FIFO depth; power of two, at least 2.
- CNT_W, 16, width of pass/fail counters; counters saturate.
- IGN_BASE, 96, first byte address of the ignored scratch window.
- IGN_SIZE, 4, byte size of the ignored window; 0 disables the window.
- DONE_ADDR, 40, completion signature address.
- DONE_DATA, 30, completion signature data.
- STOP_ON_FAIL, 1, 1: enter FAIL on first mismatch; 0: count and continue.
- TIMEOUT_CYC, 4096, watchdog limit; only used with the optional feature.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; the checker is held in reset while 0.
- start  in  1  one-cycle pulse; IDLE->RUN.
- MemWrite  in  1  store strobe from the core.
- DataAdr  in  XLEN  store address.
- WriteData  in  XLEN  store data.
- exp_valid  in  1  expected-entry push request.
- exp_ready  out  1  FIFO not full, and state is IDLE or RUN.
- exp_addr  in  XLEN  expected address.
- exp_data  in  XLEN  expected data.
- pass_count  out  CNT_W  matched stores.
- fail_count  out  CNT_W  mismatched or unexpected stores.
- pending  out  clog2(DEPTH)+1  entries in the FIFO.
- done  out  1  completion signature seen; sticky.
- failed  out  1  FAIL state reached, or timeout; sticky.
- all_pass  out  1  done & fail_count==0 & pending==0.
- fail_addr  out  XLEN  DataAdr of the first failing store.
- fail_data  out  XLEN  WriteData of the first failing store.
- state  out  2  IDLE=0, RUN=1, DONE=2, FAIL=3.

Behaviour:
- Reset values: all outputs 0, state IDLE, FIFO empty; exp_ready = 1 after reset.
- A push occurs when exp_valid & exp_ready. Push is accepted in IDLE and RUN, refused in DONE and FAIL.
- A store event is MemWrite=1 while in RUN. Stores are ignored in IDLE, DONE and FAIL.
- Each store event is classified in this priority order:
  1. Done: DataAdr==DONE_ADDR and WriteData==DONE_DATA -> state DONE, done=1. No pop; counters unchanged.
  2. Ignored: IGN_BASE <= DataAdr < IGN_BASE+IGN_SIZE -> no action.
  3. Match: FIFO non-empty and head equals (DataAdr, WriteData) -> pop, pass_count+1.
  4. Mismatch: FIFO non-empty and head differs -> pop, fail_count+1.
  5. Unexpected: FIFO empty -> fail_count+1.
- On the first mismatch or unexpected store:
  - Capture fail_addr and fail_data; they are never overwritten afterwards.
  - If STOP_ON_FAIL=1: state FAIL, failed=1.
- Counters update one cycle after the store edge (registered).
- Counters saturate at 2^CNT_W-1 and never wrap.
- Push and pop in the same cycle: pending is unchanged.
  - A pushed entry is visible at the head no earlier than the next cycle.
  - A store that arrives in the same cycle as a push into an empty FIFO is classified Unexpected.
- FIFO full: exp_ready=0 and pushes stall. A same-cycle pop does not raise exp_ready until the next cycle.
- Pointers wrap modulo DEPTH. A full/empty flag distinguishes pointer equality.
- start is ignored outside IDLE.
- DONE and FAIL are terminal; only reset leaves them.
- Reset asserted mid-run clears all state immediately (asynchronous), including FIFO contents and sticky flags.
- all_pass is combinational from registered state.

Optional Feature:
- Macro: STORE_CHECKER_TIMEOUT_EN.
- When defined:
  - A counter of width clog2(TIMEOUT_CYC)+1 increments each RUN cycle without a store event and clears on any store event.
  - On reaching TIMEOUT_CYC: state FAIL, failed=1, fail_addr=all ones, fail_data=0. This applies only if no earlier failure was captured.
- When undefined: no counter exists, and RUN can only exit via the done signature or a failure.

Test Plan:
- Push (100,25), (104,4096); start; stores (100,25), (104,4096), (40,30) -> pass_count=2, fail_count=0, done=1, all_pass=1, state=2.
- STOP_ON_FAIL=1: push (116,1); start; store (116,0) -> fail_count=1, failed=1, fail_addr=116, fail_data=0, state=3; a later (40,30) keeps state=3.
- Ignore window: start with FIFO empty; stores to 96, 97, 98, 99 then (40,30) -> fail_count=0, done=1, all_pass=1.
- FIFO boundary (DEPTH=4): push 5 entries back-to-back -> exp_ready=0 after the 4th accept, pending=4. A matching store pops, then exp_ready=1 next cycle and the 5th entry is accepted.
- STOP_ON_FAIL=0: expect (124,9), (128,9); stores (124,8), (128,9), (200,1) -> pass_count=1, fail_count=2, fail_addr=124, state stays RUN.
- Assert reset for 3 cycles mid-run with pending=2 and pass_count=1 -> all outputs 0 and state IDLE immediately. With STORE_CHECKER_TIMEOUT_EN and TIMEOUT_CYC=16: 16 idle RUN cycles -> failed=1, fail_addr=0xFFFFFFFF.

Source files
------------

// File: rtl/store_stream_checker.sv
// rtl/store_stream_checker.sv - checks core stores against an ordered expected (addr, data) queue
// Optional store watchdog: define STORE_CHECKER_TIMEOUT_EN.
module store_stream_checker #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 64,
  parameter int CNT_W        = 16,
  parameter int IGN_BASE     = 96,
  parameter int IGN_SIZE     = 4,
  parameter int DONE_ADDR    = 40,
  parameter int DONE_DATA    = 30,
  parameter int STOP_ON_FAIL = 1,
  parameter int TIMEOUT_CYC  = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     MemWrite,
  input  logic [XLEN-1:0]          DataAdr,
  input  logic [XLEN-1:0]          WriteData,
  input  logic                     exp_valid,
  output logic                     exp_ready,
  input  logic [XLEN-1:0]          exp_addr,
  input  logic [XLEN-1:0]          exp_data,
  output logic [CNT_W-1:0]         pass_count,
  output logic [CNT_W-1:0]         fail_count,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     done,
  output logic                     failed,
  output logic                     all_pass,
  output logic [XLEN-1:0]          fail_addr,
  output logic [XLEN-1:0]          fail_data,
  output logic [1:0]               state
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [XLEN-1:0] DONE_ADDR_V = XLEN'(DONE_ADDR);
  localparam logic [XLEN-1:0] DONE_DATA_V = XLEN'(DONE_DATA);
  localparam logic [XLEN:0]   IGN_LO      = (XLEN+1)'(IGN_BASE);
  localparam logic [XLEN:0]   IGN_HI      = IGN_LO + (XLEN+1)'(IGN_SIZE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  state_t            r_state;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic              r_full;
  logic [CNT_W-1:0]  r_pass;
  logic [CNT_W-1:0]  r_fail;
  logic              r_done;
  logic              r_failed;
  logic              r_captured;
  logic [XLEN-1:0]   r_fail_addr;
  logic [XLEN-1:0]   r_fail_data;
  logic [XLEN-1:0]   r_mem_addr [DEPTH];
  logic [XLEN-1:0]   r_mem_data [DEPTH];

  logic w_empty;
  logic w_push;
  logic w_store;
  logic w_is_done;
  logic w_ignored;
  logic w_classify;
  logic w_pop;
  logic w_match;
  logic w_fail_evt;
  logic w_timeout;

  assign w_empty    = (r_wr_ptr == r_rd_ptr) && !r_full;
  assign exp_ready  = !r_full && ((r_state == S_IDLE) || (r_state == S_RUN));
  assign w_push     = exp_valid && exp_ready;
  assign w_store    = MemWrite && (r_state == S_RUN);
  assign w_is_done  = (DataAdr == DONE_ADDR_V) && (WriteData == DONE_DATA_V);
  assign w_ignored  = (IGN_SIZE != 0) && ({1'b0, DataAdr} >= IGN_LO) && ({1'b0, DataAdr} < IGN_HI);
  assign w_classify = w_store && !w_is_done && !w_ignored;
  // The head is read from registered pointers, so an entry pushed this cycle is not yet visible.
  assign w_pop      = w_classify && !w_empty;
  assign w_match    = w_pop && (r_mem_addr[r_rd_ptr] == DataAdr) && (r_mem_data[r_rd_ptr] == WriteData);
  assign w_fail_evt = w_classify && !w_match;

`ifdef STORE_CHECKER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
  logic [TO_W-1:0] r_idle_cnt;

  assign w_timeout = (r_state == S_RUN) && !w_store && (r_idle_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idle_cnt <= '0;
    end else if (r_state == S_RUN) begin
      if (w_store) r_idle_cnt <= '0;
      else         r_idle_cnt <= r_idle_cnt + TO_W'(1);
    end
  end
`else
  // Watchdog not built; this expression is constant false.
  assign w_timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= exp_addr;
      r_mem_data[r_wr_ptr] <= exp_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_full      <= 1'b0;
      r_pass      <= '0;
      r_fail      <= '0;
      r_done      <= 1'b0;
      r_failed    <= 1'b0;
      r_captured  <= 1'b0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_full <= ((r_wr_ptr + AW'(1)) == r_rd_ptr);
      else if (w_pop && !w_push) r_full <= 1'b0;

      if (w_match && (r_pass != '1))    r_pass <= r_pass + CNT_W'(1);
      if (w_fail_evt && (r_fail != '1)) r_fail <= r_fail + CNT_W'(1);

      if (w_fail_evt && !r_captured) begin
        r_captured  <= 1'b1;
        r_fail_addr <= DataAdr;
        r_fail_data <= WriteData;
      end else if (w_timeout && !r_captured) begin
        r_captured  <= 1'b1;
        r_fail_addr <= '1;
        r_fail_data <= '0;
      end

      case (r_state)
        S_IDLE: if (start) r_state <= S_RUN;
        S_RUN: begin
          if (w_store && w_is_done) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (w_fail_evt && !r_captured && (STOP_ON_FAIL != 0)) begin
            r_state  <= S_FAIL;
            r_failed <= 1'b1;
          end else if (w_timeout) begin
            r_state  <= S_FAIL;
            r_failed <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign state      = r_state;
  assign pass_count = r_pass;
  assign fail_count = r_fail;
  assign pending    = r_full ? (AW+1)'(DEPTH) : {1'b0, r_wr_ptr - r_rd_ptr};
  assign done       = r_done;
  assign failed     = r_failed;
  assign fail_addr  = r_fail_addr;
  assign fail_data  = r_fail_data;
  assign all_pass   = r_done && (r_fail == '0) && (pending == '0);

endmodule
